// File: rtl/uart_tx_fifo_reader_if.sv
// Bus between the UART TX FIFO reader and its surroundings (TX FIFO read port,
// enable, serial line and status).
interface uart_tx_fifo_reader_if #(
  parameter int DATA_WIDTH = 8
);
  // Handshake: fifo_rd_en is a single-cycle pop strobe, raised only while fifo_empty
  // is low; fifo_data is the FIFO's registered output and is valid the cycle after
  // the strobe. enable is a level that permits new frames and is not acknowledged.
  logic                  enable;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  tx;
  logic                  busy;
  logic                  tx_done;
  logic [2:0]            state_dbg;

  modport master (
    input  enable, fifo_empty, fifo_data,
    output fifo_rd_en, tx, busy, tx_done, state_dbg
  );

  modport slave (
    output enable, fifo_empty, fifo_data,
    input  fifo_rd_en, tx, busy, tx_done, state_dbg
  );
endinterface

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops one FIFO word per frame and sends it LSB-first on tx.
// Optional macro UART_TX_PARITY_EN inserts a parity bit between data and stop bits.
module uart_tx_fifo_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input logic                   clk,
  input logic                   rst,
  uart_tx_fifo_reader_if.master bus
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("DATA_WIDTH must be in 5..9");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_t;

  state_t                state;
  logic                  tx_q;
  logic                  rd_q;
  logic                  busy_q;
  logic                  done_q;
  logic [BW-1:0]         baud_cnt;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  baud_last;
`ifdef UART_TX_PARITY_EN
  logic                  par_bit;
`endif

  assign baud_last     = (baud_cnt == BAUD_LAST);
  assign bus.tx         = tx_q;
  assign bus.fifo_rd_en = rd_q;
  assign bus.busy       = busy_q;
  assign bus.tx_done    = done_q;
  assign bus.state_dbg  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (bus.enable && !bus.fifo_empty) begin
            rd_q   <= 1'b1;
            busy_q <= 1'b1;
            state  <= S_WAIT;
          end
        end
        // Entered from IDLE the pop strobe is still high here, so hold one more
        // cycle until the FIFO's registered output carries the popped word.
        S_WAIT: begin
          if (!rd_q) begin
            shreg    <= bus.fifo_data;
`ifdef UART_TX_PARITY_EN
            par_bit  <= (^bus.fifo_data) ^ 1'(PARITY_ODD);
`endif
            baud_cnt <= '0;
            tx_q     <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= shreg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_bit;
              state   <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state   <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_q    <= shreg[1];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        // tx_done and the next pop are registered one cycle ahead so both land in
        // the final stop cycle, leaving a single WAIT cycle between frames.
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (rd_q) begin
                state <= S_WAIT;
              end else begin
                busy_q <= 1'b0;
                state  <= S_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
            if (bit_cnt == STOP_LAST && baud_cnt == BAUD_PRE) begin
              done_q <= 1'b1;
              if (bus.enable && !bus.fifo_empty) rd_q <= 1'b1;
            end
          end
        end
        default: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule
